// File: rtl/rst_sequencer_pkg.sv
// Shared constants and state encoding for the CCSS register-reset sequencer.
package ccss_rst_pkg;

    localparam int unsigned N_RST    = 4;
    localparam int unsigned IDX_ROW  = 0;
    localparam int unsigned IDX_COL  = 1;
    localparam int unsigned IDX_CURR = 2;
    localparam int unsigned IDX_SUM  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    function automatic logic [N_RST-1:0] idx2onehot(input logic [1:0] idx);
        return N_RST'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter; search starts at ptr_i and wraps.
module rr_arbiter4
    import ccss_rst_pkg::*;
(
    input  logic [N_RST-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_RST-1:0] gnt_o,
    output logic [1:0]       idx_o,
    output logic             valid_o
);

    logic       found;
    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_RST; k++) begin
            cand = ptr_i + k[1:0];
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        valid_o = found;
        gnt_o   = found ? idx2onehot(idx_o) : '0;
    end

endmodule

// File: rtl/rst_sequencer.sv
// Serialises ROW/COL/CURR/SUM reset requests into timed one-hot decoder pulses,
// granting round-robin and reporting per-register completion.
module rst_sequencer
    import ccss_rst_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 1,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_RST-1:0] req,
    input  logic             req_all,
    output logic [N_RST-1:0] RST_sel,
    output logic             RST_en,
    output logic [N_RST-1:0] done,
    output logic             busy
);

    localparam int unsigned   CNT_MAX   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned   CW        = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
    localparam logic          NO_GAP    = (GAP_CYC == 0);

    state_e           state_q;
    logic [N_RST-1:0] pend_q, pend_d;
    logic [1:0]       ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [N_RST-1:0] sel_q;
    logic             en_q;
    logic [N_RST-1:0] done_q;

    logic [N_RST-1:0] req_eff;
    logic [N_RST-1:0] absorb;
    logic [N_RST-1:0] cand;
    logic [N_RST-1:0] arb_gnt;
    logic [1:0]       arb_idx;
    logic             arb_valid;
    logic             decide;
    logic             grant;

    rr_arbiter4 u_arb (
        .req_i   (cand),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // A request for the bit being pulsed is dropped; during GAP it re-arms.
    always_comb begin
        req_eff = req | {N_RST{req_all}};
        absorb  = (state_q == ST_ASSERT) ? sel_q : '0;
        cand    = pend_q | (req_eff & ~absorb);
        case (state_q)
            ST_IDLE:   decide = 1'b1;
            ST_ASSERT: decide = NO_GAP && (cnt_q == '0);
            ST_GAP:    decide = (cnt_q == '0);
            default:   decide = 1'b0;
        endcase
        grant  = decide && arb_valid;
        pend_d = grant ? (cand & ~arb_gnt) : cand;
    end

    // The grant block after the case overrides the exit path on decision edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= '0;
        end else begin
            pend_q <= pend_d;
            done_q <= '0;
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        done_q  <= sel_q;
                        sel_q   <= '0;
                        en_q    <= 1'b0;
                        state_q <= NO_GAP ? ST_IDLE : ST_GAP;
                        cnt_q   <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    else             state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (grant) begin
                state_q <= ST_ASSERT;
                cnt_q   <= HOLD_LOAD;
                sel_q   <= arb_gnt;
                en_q    <= 1'b1;
                ptr_q   <= arb_idx + 2'd1;
            end
        end
    end

    assign RST_sel = sel_q;
    assign RST_en  = en_q;
    assign done    = done_q;
    assign busy    = (state_q != ST_IDLE) || (|pend_q);

endmodule
